// File: rtl/pet_dma_pkg.sv
// Shared types and defaults for the PET PRG loader: FSM state encoding,
// memory map limits and the PRG header size.
package pet_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_LO,
    ADDR_HI,
    DATA,
    PTR,
    FIN
  } state_t;

  localparam logic [15:0] RAM_TOP_DEF   = 16'h7FFF;
  localparam logic [7:0]  PTR_BASE_DEF  = 8'h2A;
  localparam int          PTR_COUNT_DEF = 3;

  // The PRG header is one little-endian 16-bit address; BASIC pointers use the same width.
  localparam int          HDR_LEN       = 2;

endpackage

// File: rtl/pet_prg_loader_if.sv
// Download-stream and DMA-port bundle of the PRG loader; master is the loader,
// slave is the host/machine side that feeds bytes and observes writes.
interface pet_prg_loader_if;

  logic        dl_start;
  logic        dl_valid;
  logic [7:0]  dl_data;
  logic        dl_ready;
  logic        dl_end;
  logic [15:0] dma_addr;
  logic [7:0]  dma_din;
  logic        dma_we;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    input  dl_start, dl_valid, dl_data, dl_end,
    output dl_ready, dma_addr, dma_din, dma_we, busy, done, error
  );

  modport slave (
    output dl_start, dl_valid, dl_data, dl_end,
    input  dl_ready, dma_addr, dma_din, dma_we, busy, done, error
  );

endinterface

// File: rtl/pet_dma_wr_reg.sv
// Registered DMA write stage; address/data hold their last value between
// writes and the strobe is high for exactly one cycle per request.
module pet_dma_wr_reg (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_req,
  input  logic [15:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_din,
  output logic        dma_we
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dma_addr <= '0;
      dma_din  <= '0;
      dma_we   <= 1'b0;
    end else begin
      dma_we <= wr_req;
      if (wr_req) begin
        dma_addr <= wr_addr;
        dma_din  <= wr_data;
      end
    end
  end

endmodule

// File: rtl/pet_prg_loader.sv
// PRG download to DMA writer: header address, payload copy into RAM, then the
// BASIC end-of-program pointers so RUN/LIST see the loaded program.
module pet_prg_loader
  import pet_dma_pkg::*;
#(
  parameter logic [15:0] RAM_TOP   = RAM_TOP_DEF,
  parameter logic [7:0]  PTR_BASE  = PTR_BASE_DEF,
  parameter int          PTR_COUNT = PTR_COUNT_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  pet_prg_loader_if.master bus
);

  localparam int PTR_WRITES = PTR_COUNT * HDR_LEN;
  localparam int CNT_W      = (PTR_WRITES > 1) ? $clog2(PTR_WRITES) : 1;

  state_t             state, state_n;
  logic [7:0]         load_lo, load_lo_n;
  logic [16:0]        cur, cur_n;
  logic [15:0]        end_addr, end_n;
  logic [CNT_W-1:0]   ptr_idx, ptr_n;
  logic               done_q, done_n;
  logic               error_q, error_n;

  logic               acc;
  logic               in_ram;
  logic [16:0]        cur_inc;
  logic [16:0]        ram_lim;
  logic [16:0]        end_clamp;
  logic               wr_req;
  logic [15:0]        wr_addr;
  logic [7:0]         wr_data;

  assign bus.dl_ready = (state == ADDR_LO) || (state == ADDR_HI) || (state == DATA);
  assign bus.busy     = bus.dl_ready || (state == PTR);
  assign bus.done     = done_q;
  assign bus.error    = error_q;

  assign acc       = bus.dl_valid && bus.dl_ready;
  assign in_ram    = (cur <= {1'b0, RAM_TOP});
  assign ram_lim   = {1'b0, RAM_TOP} + 17'd1;
  // Saturate rather than wrap so a huge stream can never come back into RAM.
  assign cur_inc   = (&cur) ? cur : cur + {16'd0, acc};
  assign end_clamp = (cur_inc > ram_lim) ? ram_lim : cur_inc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      load_lo  <= '0;
      cur      <= '0;
      end_addr <= '0;
      ptr_idx  <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state    <= state_n;
      load_lo  <= load_lo_n;
      cur      <= cur_n;
      end_addr <= end_n;
      ptr_idx  <= ptr_n;
      done_q   <= done_n;
      error_q  <= error_n;
    end
  end

  always_comb begin
    state_n   = state;
    load_lo_n = load_lo;
    cur_n     = cur;
    end_n     = end_addr;
    ptr_n     = ptr_idx;
    done_n    = done_q;
    error_n   = error_q;
    wr_req    = 1'b0;
    wr_addr   = cur[15:0];
    wr_data   = bus.dl_data;

    if (bus.dl_start) begin
      state_n = ADDR_LO;
      done_n  = 1'b0;
      error_n = 1'b0;
      ptr_n   = '0;
    end else begin
      unique case (state)
        IDLE: ;
        ADDR_LO: begin
          if (acc) load_lo_n = bus.dl_data;
          if (bus.dl_end) begin
            error_n = 1'b1;
            state_n = IDLE;
          end else if (acc) begin
            state_n = ADDR_HI;
          end
        end
        ADDR_HI: begin
          if (acc) cur_n = {1'b0, bus.dl_data, load_lo};
          // A final header byte arriving with dl_end is a valid empty program.
          if (bus.dl_end && acc) begin
            end_n   = {bus.dl_data, load_lo};
            ptr_n   = '0;
            state_n = PTR;
          end else if (bus.dl_end) begin
            error_n = 1'b1;
            state_n = IDLE;
          end else if (acc) begin
            state_n = DATA;
          end
        end
        DATA: begin
          if (acc) begin
            if (in_ram) wr_req = 1'b1;
            else        error_n = 1'b1;
            cur_n = cur_inc;
          end
          if (bus.dl_end) begin
            end_n   = end_clamp[15:0];
            ptr_n   = '0;
            state_n = PTR;
          end
        end
        PTR: begin
          wr_req  = 1'b1;
          wr_addr = {8'h00, PTR_BASE + 8'(ptr_idx)};
          wr_data = ptr_idx[0] ? end_addr[15:8] : end_addr[7:0];
          ptr_n   = ptr_idx + 1'b1;
          if (ptr_idx == CNT_W'(PTR_WRITES - 1)) begin
            done_n  = 1'b1;
            state_n = FIN;
          end
        end
        FIN: state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  pet_dma_wr_reg u_wr_reg (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .dma_addr (bus.dma_addr),
    .dma_din  (bus.dma_din),
    .dma_we   (bus.dma_we)
  );

endmodule

// File: tb/tb_pet_prg_loader.sv
// Directed bench for pet_prg_loader: streams PRG files, logs every DMA write
// and compares the log against hand-computed address/data sequences.
module tb_pet_prg_loader;

  logic clk;
  logic reset_n;

  pet_prg_loader_if bus();

  pet_prg_loader dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  logic [15:0] log_addr [256];
  logic [7:0]  log_data [256];
  int          wr_n  = 0;
  int          hi_we = 0;

  // Record every DMA write strobe seen between clock edges.
  always @(negedge clk) begin
    if (bus.dma_we === 1'b1) begin
      if (wr_n < 256) begin
        log_addr[wr_n] = bus.dma_addr;
        log_data[wr_n] = bus.dma_din;
      end
      wr_n = wr_n + 1;
      if (bus.dma_addr[15]) hi_we = hi_we + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared = compared + 1;
    assert (observed === expected)
    else begin
      mismatched = mismatched + 1;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkWrite(input string tag, input int idx, input logic [15:0] a, input logic [7:0] d);
    checkOutput({tag, "_addr"}, {16'h0, log_addr[idx]}, {16'h0, a});
    checkOutput({tag, "_data"}, {24'h0, log_data[idx]}, {24'h0, d});
  endtask

  // Checks the six pointer bytes that follow index idx.
  task automatic checkPtrs(input string tag, input int idx, input logic [15:0] end_a);
    for (int k = 0; k < 6; k++)
      checkWrite($sformatf("%s_ptr%0d", tag, k), idx + k, 16'h002A + 16'(k),
                 k[0] ? end_a[15:8] : end_a[7:0]);
  endtask

  task automatic applyStimulus(input logic s, input logic v, input logic [7:0] d, input logic e);
    bus.dl_start = s;
    bus.dl_valid = v;
    bus.dl_data  = d;
    bus.dl_end   = e;
    @(negedge clk);
    bus.dl_start = 1'b0;
    bus.dl_valid = 1'b0;
    bus.dl_data  = 8'h00;
    bus.dl_end   = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_timeout"}, {31'h0, bus.busy}, 32'h0);
    repeat (2) @(negedge clk);
  endtask

  int base;

  initial begin
    reset_n      = 1'b0;
    bus.dl_start = 1'b0;
    bus.dl_valid = 1'b0;
    bus.dl_data  = 8'h00;
    bus.dl_end   = 1'b0;

    #3;
    checkOutput("rst_dma", {7'h0, bus.dma_we, bus.dma_din, bus.dma_addr}, 32'h0);
    checkOutput("rst_flags", {28'h0, bus.dl_ready, bus.busy, bus.done, bus.error}, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_ready", {31'h0, bus.dl_ready}, 32'h0);

    // Normal load at 0401 with three bytes.
    base = wr_n;
    applyStimulus(1, 0, 8'h00, 0);
    checkOutput("t1_busy", {31'h0, bus.busy}, 32'h1);
    applyStimulus(0, 1, 8'h01, 0);
    applyStimulus(0, 1, 8'h04, 0);
    applyStimulus(0, 1, 8'hAA, 0);
    applyStimulus(0, 1, 8'hBB, 0);
    applyStimulus(0, 1, 8'hCC, 0);
    applyStimulus(0, 0, 8'h00, 1);
    waitIdle("t1");
    checkOutput("t1_count", wr_n - base, 9);
    checkWrite("t1_w0", base + 0, 16'h0401, 8'hAA);
    checkWrite("t1_w1", base + 1, 16'h0402, 8'hBB);
    checkWrite("t1_w2", base + 2, 16'h0403, 8'hCC);
    checkPtrs("t1", base + 3, 16'h0404);
    checkOutput("t1_done", {31'h0, bus.done}, 32'h1);
    checkOutput("t1_error", {31'h0, bus.error}, 32'h0);

    // Overflow past RAM_TOP: third byte is dropped.
    base = wr_n;
    applyStimulus(1, 0, 8'h00, 0);
    applyStimulus(0, 1, 8'hFE, 0);
    applyStimulus(0, 1, 8'h7F, 0);
    applyStimulus(0, 1, 8'h11, 0);
    applyStimulus(0, 1, 8'h22, 0);
    applyStimulus(0, 1, 8'h33, 0);
    applyStimulus(0, 0, 8'h00, 1);
    waitIdle("t2");
    checkOutput("t2_count", wr_n - base, 8);
    checkWrite("t2_w0", base + 0, 16'h7FFE, 8'h11);
    checkWrite("t2_w1", base + 1, 16'h7FFF, 8'h22);
    checkPtrs("t2", base + 2, 16'h8000);
    checkOutput("t2_error", {31'h0, bus.error}, 32'h1);

    // Short file: only one header byte.
    base = wr_n;
    applyStimulus(1, 0, 8'h00, 0);
    applyStimulus(0, 1, 8'h01, 0);
    applyStimulus(0, 0, 8'h00, 1);
    waitIdle("t3");
    checkOutput("t3_count", wr_n - base, 0);
    checkOutput("t3_flags", {29'h0, bus.dl_ready, bus.done, bus.error}, 32'h1);

    // Last byte together with dl_end.
    base = wr_n;
    applyStimulus(1, 0, 8'h00, 0);
    applyStimulus(0, 1, 8'h00, 0);
    applyStimulus(0, 1, 8'h05, 0);
    applyStimulus(0, 1, 8'h77, 1);
    waitIdle("t4");
    checkOutput("t4_count", wr_n - base, 7);
    checkWrite("t4_w0", base + 0, 16'h0500, 8'h77);
    checkPtrs("t4", base + 1, 16'h0501);
    checkOutput("t4_done_err", {30'h0, bus.done, bus.error}, 32'h2);

    // Abort mid-DATA, then a fresh load at 1000.
    base = wr_n;
    applyStimulus(1, 0, 8'h00, 0);
    applyStimulus(0, 1, 8'h00, 0);
    applyStimulus(0, 1, 8'h20, 0);
    applyStimulus(0, 1, 8'h01, 0);
    applyStimulus(0, 1, 8'h02, 0);
    applyStimulus(1, 0, 8'h00, 0);
    checkOutput("t5_cleared", {30'h0, bus.done, bus.error}, 32'h0);
    applyStimulus(0, 1, 8'h00, 0);
    applyStimulus(0, 1, 8'h10, 0);
    applyStimulus(0, 1, 8'h55, 0);
    applyStimulus(0, 0, 8'h00, 1);
    waitIdle("t5");
    checkOutput("t5_count", wr_n - base, 9);
    checkWrite("t5_w0", base + 0, 16'h2000, 8'h01);
    checkWrite("t5_w1", base + 1, 16'h2001, 8'h02);
    checkWrite("t5_w2", base + 2, 16'h1000, 8'h55);
    checkPtrs("t5", base + 3, 16'h1001);

    // Asynchronous reset while a payload write is on the bus.
    applyStimulus(1, 0, 8'h00, 0);
    applyStimulus(0, 1, 8'h00, 0);
    applyStimulus(0, 1, 8'h30, 0);
    applyStimulus(0, 1, 8'h11, 0);
    checkOutput("t6_pre_we", {15'h0, bus.dma_we, bus.dma_addr}, 32'h0001_3000);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("t6_rst_dma", {7'h0, bus.dma_we, bus.dma_din, bus.dma_addr}, 32'h0);
    checkOutput("t6_rst_flags", {28'h0, bus.dl_ready, bus.busy, bus.done, bus.error}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("t6_idle", {29'h0, bus.dl_ready, bus.busy, bus.dma_we}, 32'h0);
    applyStimulus(1, 0, 8'h00, 0);
    checkOutput("t6_restart", {30'h0, bus.dl_ready, bus.busy}, 32'h3);

    checkOutput("rom_writes", hi_we, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
